// File: rtl/smem_result_writer_pkg.sv
// Shared pipeline constants, entry layout and writer state encoding.
// Entry field offsets match the per-batch loader so the host uses one layout.
// No logic beyond the pure pack_entry helper.
package smem_result_writer_pkg;

  localparam int CL             = 512;
  localparam int READ_NUM_WIDTH = 9;
  localparam int ENTRY_W        = 256;
  localparam logic [ENTRY_W-1:0] FILLER_ENTRY = '1;

  // Interval fields carry 33 meaningful bits each.
  localparam int IK_W = 33;

  // Word base offsets inside one 256-bit entry.
  localparam int W0_LSB = 0;
  localparam int W1_LSB = 64;
  localparam int W2_LSB = 128;
  localparam int W3_LSB = 192;

  // Field offsets inside word3.
  localparam int RN_LSB      = 48;
  localparam int INFO_HI_LSB = 32;
  localparam int INFO_LO_LSB = 0;
  localparam int INFO_W      = 7;

  typedef enum logic [2:0] {
    ST_COLLECT,
    ST_FLUSH,
    ST_TRAILER,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Build one entry; all bits outside the named fields are zero.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [READ_NUM_WIDTH-1:0] rn,
    input logic [63:0]               x0,
    input logic [63:0]               x1,
    input logic [63:0]               x2,
    input logic [63:0]               info
  );
    logic [ENTRY_W-1:0] e;
    e = '0;
    e[W0_LSB +: IK_W]                   = x0[IK_W-1:0];
    e[W1_LSB +: IK_W]                   = x1[IK_W-1:0];
    e[W2_LSB +: IK_W]                   = x2[IK_W-1:0];
    e[W3_LSB + RN_LSB +: READ_NUM_WIDTH] = rn;
    e[W3_LSB + INFO_HI_LSB +: INFO_W]   = info[INFO_HI_LSB +: INFO_W];
    e[W3_LSB + INFO_LO_LSB +: INFO_W]   = info[INFO_LO_LSB +: INFO_W];
    return e;
  endfunction

endpackage

// File: rtl/smem_result_writer_cl_fifo.sv
// Synchronous show-ahead FIFO holding {last, line} words for the host stream.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: pushes while full are ignored; the caller must watch o_full.
module smem_result_writer_cl_fifo #(
  parameter int WIDTH = 513,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_push_dat,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head_dat,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == DEPTH_C);
  assign o_count   = r_count;
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  // Head reads as zero when empty so reset also clears the presented line.
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/smem_result_writer.sv
// Packs SMEM results two per cache line, then flushes, appends a trailer and flags batch done.
// Latency: a completed pair appears on o_out_data one cycle after its second result is accepted.
// Backpressure: registered o_stall at FIFO_DEPTH-2 lines; host throttles with i_out_ready.
module smem_result_writer
  import smem_result_writer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic [READ_NUM_WIDTH:0]   i_batch_size,
  input  logic                      i_res_valid,
  input  logic [READ_NUM_WIDTH-1:0] i_res_read_num,
  input  logic [63:0]               i_res_ik_x0,
  input  logic [63:0]               i_res_ik_x1,
  input  logic [63:0]               i_res_ik_x2,
  input  logic [63:0]               i_res_ik_info,
  input  logic                      i_read_done,
  output logic                      o_stall,
  output logic                      o_out_valid,
  output logic [CL-1:0]             o_out_data,
  output logic                      o_out_last,
  input  logic                      i_out_ready,
  output logic                      o_batch_done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Two lines of headroom: one in-flight result cycle plus the flush/trailer pair.
  localparam logic [CW-1:0] STALL_LVL = CW'(FIFO_DEPTH - 2);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ENTRY_W-1:0]   r_half;
  logic                 r_half_vld;
  logic [31:0]          r_entry_cnt;
  logic [READ_NUM_WIDTH:0] r_reads_fin;
  logic                 r_stall;
  logic                 r_trailer_acc;

  logic [ENTRY_W-1:0]   w_entry;
  logic                 w_accept;
  logic                 w_pair_push;
  logic                 w_fsm_push;
  logic [CL:0]          w_fsm_dat;
  logic                 w_push;
  logic [CL:0]          w_push_dat;
  logic                 w_pop;
  logic [CL:0]          w_head;
  logic [CW-1:0]        w_count;
  logic                 w_full;
  logic                 w_empty;

  assign w_entry     = pack_entry(i_res_read_num, i_res_ik_x0, i_res_ik_x1,
                                  i_res_ik_x2, i_res_ik_info);
  assign w_accept    = i_res_valid && (r_state == ST_COLLECT);
  assign w_pair_push = w_accept && r_half_vld;
  assign w_push      = w_pair_push || w_fsm_push;
  assign w_push_dat  = w_pair_push ? {1'b0, w_entry, r_half} : w_fsm_dat;
  assign w_pop       = !w_empty && i_out_ready;

  assign o_stall      = r_stall;
  assign o_out_valid  = !w_empty;
  assign o_out_data   = w_head[CL-1:0];
  assign o_out_last   = w_head[CL];
  assign o_batch_done = (r_state == ST_DONE);

  smem_result_writer_cl_fifo #(
    .WIDTH (CL + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .o_head_dat (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Batch state register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= ST_COLLECT;
    else            r_state <= w_state_nxt;
  end

  // Next state plus the flush and trailer pushes.
  always_comb begin
    w_state_nxt = r_state;
    w_fsm_push  = 1'b0;
    w_fsm_dat   = '0;
    case (r_state)
      ST_COLLECT: begin
        if ((r_reads_fin == i_batch_size) && (i_batch_size != '0) && !i_res_valid)
          w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (!r_half_vld) begin
          w_state_nxt = ST_TRAILER;
        end else if (!w_full) begin
          w_fsm_push  = 1'b1;
          w_fsm_dat   = {1'b0, FILLER_ENTRY, r_half};
          w_state_nxt = ST_TRAILER;
        end
      end
      ST_TRAILER: begin
        if (!w_full) begin
          w_fsm_push  = 1'b1;
          w_fsm_dat   = {1'b1, {(CL-32){1'b0}}, r_entry_cnt};
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_empty && r_trailer_acc) w_state_nxt = ST_DONE;
      end
      ST_DONE:  w_state_nxt = ST_DONE;
      default:  w_state_nxt = ST_COLLECT;
    endcase
  end

  // Half register, counters, registered stall and trailer handshake tracking.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_half        <= '0;
      r_half_vld    <= 1'b0;
      r_entry_cnt   <= '0;
      r_reads_fin   <= '0;
      r_stall       <= 1'b0;
      r_trailer_acc <= 1'b0;
    end else begin
      if (w_accept) begin
        r_entry_cnt <= r_entry_cnt + 32'd1;
        if (r_half_vld) begin
          r_half_vld <= 1'b0;
        end else begin
          r_half     <= w_entry;
          r_half_vld <= 1'b1;
        end
      end else if (w_fsm_push && (r_state == ST_FLUSH)) begin
        r_half_vld <= 1'b0;
      end
      if (i_read_done) r_reads_fin <= r_reads_fin + 1'b1;
      r_stall <= (w_count >= STALL_LVL);
      if (w_pop && w_head[CL]) r_trailer_acc <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // A push into a full line FIFO would lose a line.
  a_no_overflow: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(w_push && w_full));
  // Results must not arrive after the batch has been closed.
  a_no_late_result: assert property (@(posedge i_clk) disable iff (!i_reset_n)
    !(i_res_valid && ((r_state == ST_FLUSH) || (r_state == ST_TRAILER) ||
                      (r_state == ST_DRAIN))));
`endif

endmodule

// File: tb/tb_smem_result_writer.sv
// Directed bench for smem_result_writer: packing, flush, backpressure, reset and zero batch.
// Inputs change 1 time unit after the rising edge; host lines are captured on the falling edge.
// Expected lines are built from a local entry model and hand-computed constants.
module tb_smem_result_writer;

  logic         i_clk = 1'b0;
  logic         i_reset_n;
  logic [9:0]   i_batch_size;
  logic         i_res_valid;
  logic [8:0]   i_res_read_num;
  logic [63:0]  i_res_ik_x0;
  logic [63:0]  i_res_ik_x1;
  logic [63:0]  i_res_ik_x2;
  logic [63:0]  i_res_ik_info;
  logic         i_read_done;
  logic         o_stall;
  logic         o_out_valid;
  logic [511:0] o_out_data;
  logic         o_out_last;
  logic         i_out_ready;
  logic         o_batch_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [511:0] q_dat[$];
  logic         q_last[$];

  localparam logic [255:0] FILL = {256{1'b1}};

  always #5 i_clk = ~i_clk;

  smem_result_writer dut (
    .i_clk          (i_clk),
    .i_reset_n      (i_reset_n),
    .i_batch_size   (i_batch_size),
    .i_res_valid    (i_res_valid),
    .i_res_read_num (i_res_read_num),
    .i_res_ik_x0    (i_res_ik_x0),
    .i_res_ik_x1    (i_res_ik_x1),
    .i_res_ik_x2    (i_res_ik_x2),
    .i_res_ik_info  (i_res_ik_info),
    .i_read_done    (i_read_done),
    .o_stall        (o_stall),
    .o_out_valid    (o_out_valid),
    .o_out_data     (o_out_data),
    .o_out_last     (o_out_last),
    .i_out_ready    (i_out_ready),
    .o_batch_done   (o_batch_done)
  );

  // Record every line the host accepts at the following rising edge.
  always @(negedge i_clk) begin
    if (i_reset_n && o_out_valid && i_out_ready) begin
      q_dat.push_back(o_out_data);
      q_last.push_back(o_out_last);
    end
  end

  function automatic logic [255:0] exp_entry(input logic [8:0] rn, input logic [63:0] a,
                                             input logic [63:0] b, input logic [63:0] c,
                                             input logic [63:0] d);
    logic [63:0] w3;
    w3 = {7'b0, rn, 9'b0, d[38:32], 25'b0, d[6:0]};
    return {w3, 31'b0, c[32:0], 31'b0, b[32:0], 31'b0, a[32:0]};
  endfunction

  function automatic logic [511:0] line_at(input int i);
    if (i < q_dat.size()) return q_dat[i];
    return 'x;
  endfunction

  function automatic logic last_at(input int i);
    if (i < q_last.size()) return q_last[i];
    return 1'bx;
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic apply_reset();
    i_reset_n      = 1'b0;
    i_res_valid    = 1'b0;
    i_read_done    = 1'b0;
    i_res_read_num = '0;
    i_res_ik_x0    = '0;
    i_res_ik_x1    = '0;
    i_res_ik_x2    = '0;
    i_res_ik_info  = '0;
    i_out_ready    = 1'b0;
    i_batch_size   = '0;
    repeat (2) step();
    i_reset_n = 1'b1;
    q_dat.delete();
    q_last.delete();
    step();
  endtask

  task automatic send(input logic [8:0] rn, input logic [63:0] a, input logic [63:0] b,
                      input logic [63:0] c, input logic [63:0] d, input logic done);
    i_res_valid    = 1'b1;
    i_res_read_num = rn;
    i_res_ik_x0    = a;
    i_res_ik_x1    = b;
    i_res_ik_x2    = c;
    i_res_ik_info  = d;
    i_read_done    = done;
    step();
    i_res_valid = 1'b0;
    i_read_done = 1'b0;
  endtask

  task automatic pulse_done();
    i_read_done = 1'b1;
    step();
    i_read_done = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (o_batch_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", o_out_valid); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", o_stall); else n_pass++;
    n_total++; if (o_out_data !== 512'd0) $display("FAIL reset_data: got %h want 0", o_out_data); else n_pass++;
    n_total++; if (o_out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", o_out_last); else n_pass++;
    n_total++; if (o_batch_done !== 1'b0) $display("FAIL reset_done: got %b want 0", o_batch_done); else n_pass++;
  endtask

  task automatic test_pair();
    bit ok;
    logic [511:0] l0;
    logic [511:0] l1;
    apply_reset();
    i_batch_size = 10'd1;
    i_out_ready  = 1'b1;
    send(9'd0, 64'h1_0000_0001, 64'hFFFF_FFFE_0000_0003, 64'h0000_0001_8000_0000,
         64'hABCD_EFC5_1234_5692, 1'b0);
    send(9'd0, 64'h5, 64'h0, 64'h0, 64'h0, 1'b0);
    // Pair line is presented one cycle after the second result is accepted.
    n_total++; if (o_out_valid !== 1'b1) $display("FAIL pair_latency_valid: got %b want 1", o_out_valid); else n_pass++;
    n_total++; if (o_out_data[288:256] !== 33'h5) $display("FAIL pair_latency_data: got %h want 5", o_out_data[288:256]); else n_pass++;
    pulse_done();
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL pair_done_timeout: batch_done=%b want 1", o_batch_done); else n_pass++;
    step();
    n_total++; if (q_dat.size() !== 2) $display("FAIL pair_line_count: got %0d want 2", q_dat.size()); else n_pass++;
    l0 = line_at(0);
    l1 = line_at(1);
    n_total++; if (l0[32:0] !== 33'h1_0000_0001) $display("FAIL pair_x0_a: got %h want 100000001", l0[32:0]); else n_pass++;
    n_total++; if (l0[288:256] !== 33'h5) $display("FAIL pair_x0_b: got %h want 5", l0[288:256]); else n_pass++;
    n_total++; if (l0[127:64] !== 64'h3) $display("FAIL pair_x1_mask: got %h want 3", l0[127:64]); else n_pass++;
    n_total++; if (l0[191:128] !== 64'h1_8000_0000) $display("FAIL pair_x2_mask: got %h want 180000000", l0[191:128]); else n_pass++;
    n_total++; if (l0[255:192] !== 64'h0000_0045_0000_0012) $display("FAIL pair_word3: got %h want 0000004500000012", l0[255:192]); else n_pass++;
    n_total++; if (last_at(0) !== 1'b0) $display("FAIL pair_last0: got %b want 0", last_at(0)); else n_pass++;
    n_total++; if (l1 !== 512'd2) $display("FAIL pair_trailer: got %h want 2", l1); else n_pass++;
    n_total++; if (last_at(1) !== 1'b1) $display("FAIL pair_last1: got %b want 1", last_at(1)); else n_pass++;
    n_total++; if (o_batch_done !== 1'b1) $display("FAIL pair_done_sticky: got %b want 1", o_batch_done); else n_pass++;
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL pair_idle_valid: got %b want 0", o_out_valid); else n_pass++;
  endtask

  task automatic test_odd_flush();
    bit ok;
    logic [255:0] e0;
    logic [255:0] e1;
    logic [255:0] e2;
    logic [511:0] l0;
    logic [511:0] l1;
    apply_reset();
    i_batch_size = 10'd2;
    i_out_ready  = 1'b1;
    e0 = exp_entry(9'd0, 64'h11, 64'h12, 64'h13, 64'h01);
    e1 = exp_entry(9'd1, 64'h21, 64'h22, 64'h23, 64'h02);
    e2 = exp_entry(9'd1, 64'h31, 64'h32, 64'h33, 64'h03);
    send(9'd0, 64'h11, 64'h12, 64'h13, 64'h01, 1'b0);
    pulse_done();
    send(9'd1, 64'h21, 64'h22, 64'h23, 64'h02, 1'b0);
    send(9'd1, 64'h31, 64'h32, 64'h33, 64'h03, 1'b0);
    pulse_done();
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL odd_done_timeout: batch_done=%b want 1", o_batch_done); else n_pass++;
    step();
    l0 = line_at(0);
    l1 = line_at(1);
    n_total++; if (q_dat.size() !== 3) $display("FAIL odd_line_count: got %0d want 3", q_dat.size()); else n_pass++;
    n_total++; if (l0 !== {e1, e0}) $display("FAIL odd_line0: got %h want %h", l0, {e1, e0}); else n_pass++;
    n_total++; if (l0[511:496] !== 16'h0001) $display("FAIL odd_read_num: got %h want 0001", l0[511:496]); else n_pass++;
    n_total++; if (l1[511:256] !== FILL) $display("FAIL odd_filler: got %h want all ones", l1[511:256]); else n_pass++;
    n_total++; if (l1[255:0] !== e2) $display("FAIL odd_half: got %h want %h", l1[255:0], e2); else n_pass++;
    n_total++; if (line_at(2) !== 512'd3) $display("FAIL odd_trailer: got %h want 3", line_at(2)); else n_pass++;
    n_total++; if (last_at(1) !== 1'b0 || last_at(2) !== 1'b1) $display("FAIL odd_last: got %b%b want 01", last_at(1), last_at(2)); else n_pass++;
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [255:0] ea;
    logic [255:0] eb;
    int bad;
    apply_reset();
    i_batch_size = 10'd1;
    i_out_ready  = 1'b0;
    for (int i = 0; i < 10; i++)
      send(9'(i), 64'h1_0000_0000 | 64'(i), 64'(i * 3), ~64'(i), 64'(i), 1'b0);
    step();
    n_total++; if (o_stall !== 1'b0) $display("FAIL bp_stall_low: got %b want 0 at 5 lines", o_stall); else n_pass++;
    for (int i = 10; i < 12; i++)
      send(9'(i), 64'h1_0000_0000 | 64'(i), 64'(i * 3), ~64'(i), 64'(i), 1'b0);
    step();
    n_total++; if (o_stall !== 1'b1) $display("FAIL bp_stall_high: got %b want 1 at 6 lines", o_stall); else n_pass++;
    for (int i = 12; i < 14; i++)
      send(9'(i), 64'h1_0000_0000 | 64'(i), 64'(i * 3), ~64'(i), 64'(i), 1'b0);
    n_total++; if (o_out_valid !== 1'b1 || o_out_last !== 1'b0) $display("FAIL bp_hold: valid=%b last=%b want 1 0", o_out_valid, o_out_last); else n_pass++;
    n_total++; if (q_dat.size() !== 0) $display("FAIL bp_no_pop: got %0d lines want 0", q_dat.size()); else n_pass++;
    pulse_done();
    repeat (4) step();
    i_out_ready = 1'b1;
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL bp_done_timeout: batch_done=%b want 1", o_batch_done); else n_pass++;
    step();
    n_total++; if (q_dat.size() !== 8) $display("FAIL bp_line_count: got %0d want 8", q_dat.size()); else n_pass++;
    bad = 0;
    for (int k = 0; k < 7; k++) begin
      ea = exp_entry(9'(2 * k), 64'h1_0000_0000 | 64'(2 * k), 64'(2 * k * 3), ~64'(2 * k), 64'(2 * k));
      eb = exp_entry(9'(2 * k + 1), 64'h1_0000_0000 | 64'(2 * k + 1), 64'((2 * k + 1) * 3),
                     ~64'(2 * k + 1), 64'(2 * k + 1));
      if (line_at(k) !== {eb, ea} || last_at(k) !== 1'b0) bad++;
    end
    n_total++; if (bad != 0) $display("FAIL bp_order: %0d of 7 lines wrong, want 0", bad); else n_pass++;
    n_total++; if (line_at(7) !== 512'd14 || last_at(7) !== 1'b1) $display("FAIL bp_trailer: got %h last=%b want 14 last=1", line_at(7), last_at(7)); else n_pass++;
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [255:0] e0;
    logic [255:0] e1;
    apply_reset();
    i_batch_size = 10'd1;
    i_out_ready  = 1'b1;
    e0 = exp_entry(9'd7, 64'hAA, 64'hBB, 64'hCC, 64'h7F);
    e1 = exp_entry(9'd7, 64'hDD, 64'hEE, 64'hFF, 64'h7F_0000_0000);
    send(9'd7, 64'hAA, 64'hBB, 64'hCC, 64'h7F, 1'b0);
    send(9'd7, 64'hDD, 64'hEE, 64'hFF, 64'h7F_0000_0000, 1'b1);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL sim_done_timeout: batch_done=%b want 1", o_batch_done); else n_pass++;
    step();
    n_total++; if (q_dat.size() !== 2) $display("FAIL sim_line_count: got %0d want 2", q_dat.size()); else n_pass++;
    n_total++; if (line_at(0) !== {e1, e0}) $display("FAIL sim_line0: got %h want %h", line_at(0), {e1, e0}); else n_pass++;
    n_total++; if (line_at(1) !== 512'd2) $display("FAIL sim_trailer: got %h want 2", line_at(1)); else n_pass++;
  endtask

  task automatic test_reset_midstream();
    bit ok;
    logic [255:0] e0;
    apply_reset();
    i_batch_size = 10'd1;
    i_out_ready  = 1'b0;
    for (int i = 0; i < 13; i++)
      send(9'(i), 64'(i), 64'(i), 64'(i), 64'(i), 1'b0);
    step();
    n_total++; if (o_stall !== 1'b1 || o_out_valid !== 1'b1) $display("FAIL mid_pre: stall=%b valid=%b want 1 1", o_stall, o_out_valid); else n_pass++;
    i_reset_n = 1'b0;
    #1;
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", o_out_valid); else n_pass++;
    n_total++; if (o_stall !== 1'b0) $display("FAIL mid_stall: got %b want 0", o_stall); else n_pass++;
    n_total++; if (o_batch_done !== 1'b0) $display("FAIL mid_done: got %b want 0", o_batch_done); else n_pass++;
    n_total++; if (o_out_data !== 512'd0) $display("FAIL mid_data: got %h want 0", o_out_data); else n_pass++;
    step();
    i_reset_n = 1'b1;
    q_dat.delete();
    q_last.delete();
    step();
    i_out_ready = 1'b1;
    e0 = exp_entry(9'd3, 64'h77, 64'h88, 64'h99, 64'h05);
    send(9'd3, 64'h77, 64'h88, 64'h99, 64'h05, 1'b1);
    wait_done(ok);
    n_total++; if (!ok) $display("FAIL mid_done_timeout: batch_done=%b want 1", o_batch_done); else n_pass++;
    step();
    n_total++; if (line_at(0) !== {FILL, e0}) $display("FAIL mid_half_empty: got %h want %h", line_at(0), {FILL, e0}); else n_pass++;
    n_total++; if (line_at(1) !== 512'd1) $display("FAIL mid_trailer: got %h want 1", line_at(1)); else n_pass++;
  endtask

  task automatic test_zero_batch();
    apply_reset();
    i_batch_size = 10'd0;
    i_out_ready  = 1'b1;
    repeat (3) pulse_done();
    repeat (20) step();
    n_total++; if (q_dat.size() !== 0) $display("FAIL zero_lines: got %0d want 0", q_dat.size()); else n_pass++;
    n_total++; if (o_batch_done !== 1'b0) $display("FAIL zero_done: got %b want 0", o_batch_done); else n_pass++;
    n_total++; if (o_out_valid !== 1'b0) $display("FAIL zero_valid: got %b want 0", o_out_valid); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_pair();
    test_odd_flush();
    test_backpressure();
    test_simultaneous();
    test_reset_midstream();
    test_zero_batch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
